// File: rtl/data_access_unit.sv
// Load/store stage between the core's ALU/decoder and a word-addressed data memory.
// Checks alignment and range, then runs a valid/ack access with byte lanes and a timeout.
module data_access_unit #(
   parameter logic [31:0] DATA_BASE  = 32'h0000_2000,
   parameter int          DATA_SIZE  = 4096,
   parameter int          ADDR_WIDTH = 10,
   parameter int          TIMEOUT    = 15
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rd,
   input  logic                  wd,
   input  logic [1:0]            size,
   input  logic [31:0]           addr,
   input  logic [31:0]           data_in,
   output logic [31:0]           data_out,
   output logic                  ready,
   output logic                  busy,
   output logic                  done,
   output logic [1:0]            fault,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [3:0]            mem_be,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   input  logic                  mem_ack,
   input  logic [31:0]           mem_rdata
);

   localparam logic [32:0] LIMIT      = {1'b0, DATA_BASE} + 33'(DATA_SIZE);
   localparam logic [7:0]  TIMEOUT_M1 = 8'(TIMEOUT - 1);

   localparam logic [1:0] FAULT_NONE    = 2'b00;
   localparam logic [1:0] FAULT_ALIGN   = 2'b01;
   localparam logic [1:0] FAULT_ACCESS  = 2'b10;
   localparam logic [1:0] FAULT_TIMEOUT = 2'b11;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ACCESS = 2'b01,
      DONE   = 2'b10
   } state_t;

   state_t state;
   state_t next_state;

   logic        armed;
   logic [1:0]  lane_q;
   logic [1:0]  size_q;
   logic        write_q;
   logic [7:0]  count;

   logic                  accept;
   logic                  illegal;
   logic                  misaligned;
   logic                  out_of_range;
   logic [1:0]            req_fault;
   logic                  timed_out;
   logic [3:0]            be_calc;
   logic [31:0]           wdata_calc;
   logic [ADDR_WIDTH-1:0] word_offset;
   logic [31:0]           shifted;
   logic [31:0]           load_value;

   // Request decode and checks on the live core inputs, used only at the accept edge.
   always_comb begin
      accept       = armed && (state == IDLE) && (rd || wd);
      illegal      = (rd && wd) || (size == 2'b11);
      misaligned   = ((size == 2'b01) && addr[0]) ||
                     ((size == 2'b10) && (addr[1:0] != 2'b00));
      out_of_range = (addr < DATA_BASE) || ({1'b0, addr} >= LIMIT);
      if (illegal)
         req_fault = FAULT_ACCESS;
      else if (misaligned)
         req_fault = FAULT_ALIGN;
      else if (out_of_range)
         req_fault = FAULT_ACCESS;
      else
         req_fault = FAULT_NONE;
   end

   // Byte lanes, replicated store data and word offset into the window.
   // The word offset subtracts the word parts and borrows from the byte parts,
   // which equals bits [ADDR_WIDTH+1:2] of the full byte-address difference.
   always_comb begin
      be_calc    = 4'b1111;
      wdata_calc = data_in;
      case (size)
         2'b00: begin
            be_calc    = 4'b0001 << addr[1:0];
            wdata_calc = {4{data_in[7:0]}};
         end
         2'b01: begin
            be_calc    = 4'b0011 << addr[1:0];
            wdata_calc = {2{data_in[15:0]}};
         end
         default: begin
            be_calc    = 4'b1111;
            wdata_calc = data_in;
         end
      endcase
      word_offset = addr[ADDR_WIDTH+1:2] - DATA_BASE[ADDR_WIDTH+1:2]
                    - ADDR_WIDTH'(addr[1:0] < DATA_BASE[1:0]);
   end

   // Load data is right-justified from the addressed lane and zero-extended.
   always_comb begin
      shifted   = mem_rdata >> {lane_q, 3'b000};
      timed_out = (count == TIMEOUT_M1);
      case (size_q)
         2'b00:   load_value = {24'h000000, shifted[7:0]};
         2'b01:   load_value = {16'h0000, shifted[15:0]};
         default: load_value = shifted;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst)
         state <= IDLE;
      else
         state <= next_state;
   end

   // Faulted requests skip the memory entirely; ack wins over a coincident timeout.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (accept)
               next_state = (req_fault != FAULT_NONE) ? DONE : ACCESS;
         end
         ACCESS: begin
            if (mem_ack || timed_out)
               next_state = DONE;
         end
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // armed stays low for the first cycle after reset so ready rises one edge late.
   always_ff @(posedge clk) begin
      if (!rst) begin
         armed     <= 1'b0;
         lane_q    <= 2'b00;
         size_q    <= 2'b00;
         write_q   <= 1'b0;
         count     <= 8'd0;
         fault     <= FAULT_NONE;
         data_out  <= 32'h0000_0000;
         mem_be    <= 4'b0000;
         mem_addr  <= '0;
         mem_wdata <= 32'h0000_0000;
      end else begin
         armed <= 1'b1;
         if (accept) begin
            lane_q  <= addr[1:0];
            size_q  <= size;
            write_q <= wd;
            count   <= 8'd0;
            fault   <= req_fault;
            if (req_fault == FAULT_NONE) begin
               mem_be    <= be_calc;
               mem_addr  <= word_offset;
               mem_wdata <= wdata_calc;
            end
         end else if (state == ACCESS) begin
            if (mem_ack) begin
               if (!write_q)
                  data_out <= load_value;
            end else if (timed_out) begin
               fault <= FAULT_TIMEOUT;
            end else begin
               count <= count + 8'd1;
            end
         end
      end
   end

   always_comb begin
      ready   = armed && (state == IDLE);
      busy    = (state == ACCESS);
      done    = (state == DONE);
      mem_req = (state == ACCESS);
      mem_we  = (state == ACCESS) && write_q;
   end

endmodule

// File: tb/tb_data_access_unit.sv
// Directed bench for data_access_unit: loads, stores, faults, timeout and mid-access reset.
// A tiny inline memory responder is driven by hand from the single stimulus sequence.
module tb_data_access_unit;

   logic        clk;
   logic        rst;
   logic        rd;
   logic        wd;
   logic [1:0]  size;
   logic [31:0] addr;
   logic [31:0] data_in;
   logic [31:0] data_out;
   logic        ready;
   logic        busy;
   logic        done;
   logic [1:0]  fault;
   logic        mem_req;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   int check_count;
   int pass_count;
   int req_cycles;

   data_access_unit dut (
      .clk       (clk),
      .rst       (rst),
      .rd        (rd),
      .wd        (wd),
      .size      (size),
      .addr      (addr),
      .data_in   (data_in),
      .data_out  (data_out),
      .ready     (ready),
      .busy      (busy),
      .done      (done),
      .fault     (fault),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_be    (mem_be),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to just after the next rising edge so outputs have settled.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic r, input logic w, input logic [1:0] s,
                                input logic [31:0] a, input logic [31:0] d);
      rd      = r;
      wd      = w;
      size    = s;
      addr    = a;
      data_in = d;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      check_count++;
      assert (observed === expected) pass_count++;
      else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
   endtask

   // Issue one request at the next edge, then drop the strobes.
   task automatic issue(input logic r, input logic w, input logic [1:0] s,
                        input logic [31:0] a, input logic [31:0] d);
      applyStimulus(r, w, s, a, d);
      tick();
      applyStimulus(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
   endtask

   initial begin
      check_count = 0;
      pass_count  = 0;
      rst       = 1'b0;
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      applyStimulus(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);

      tick();
      tick();
      checkOutput("rst_ready",    32'(ready),   32'h0);
      checkOutput("rst_busy",     32'(busy),    32'h0);
      checkOutput("rst_done",     32'(done),    32'h0);
      checkOutput("rst_req",      32'(mem_req), 32'h0);
      checkOutput("rst_we",       32'(mem_we),  32'h0);
      checkOutput("rst_fault",    32'(fault),   32'h0);
      checkOutput("rst_data_out", data_out,     32'h0);
      checkOutput("rst_be",       32'(mem_be),  32'h0);
      checkOutput("rst_addr",     32'(mem_addr), 32'h0);
      checkOutput("rst_wdata",    mem_wdata,    32'h0);

      rst = 1'b1;
      tick();
      checkOutput("ready_after_rst", 32'(ready), 32'h1);

      $display("[TB] word load");
      issue(1'b1, 1'b0, 2'b10, 32'h0000_2004, 32'h0);
      checkOutput("wl_req",   32'(mem_req),  32'h1);
      checkOutput("wl_busy",  32'(busy),     32'h1);
      checkOutput("wl_ready", 32'(ready),    32'h0);
      checkOutput("wl_addr",  32'(mem_addr), 32'h1);
      checkOutput("wl_be",    32'(mem_be),   32'hF);
      checkOutput("wl_we",    32'(mem_we),   32'h0);
      mem_ack   = 1'b1;
      mem_rdata = 32'hDEAD_BEEF;
      tick();
      mem_ack = 1'b0;
      checkOutput("wl_done",  32'(done),    32'h1);
      checkOutput("wl_data",  data_out,     32'hDEAD_BEEF);
      checkOutput("wl_fault", 32'(fault),   32'h0);
      checkOutput("wl_req_off", 32'(mem_req), 32'h0);
      tick();
      checkOutput("wl_done_once", 32'(done), 32'h0);
      checkOutput("wl_idle",      32'(ready), 32'h1);

      $display("[TB] byte store");
      issue(1'b0, 1'b1, 2'b00, 32'h0000_2003, 32'h0000_00A5);
      checkOutput("bs_be",    32'(mem_be),   32'h8);
      checkOutput("bs_wdata", mem_wdata,     32'hA5A5_A5A5);
      checkOutput("bs_we",    32'(mem_we),   32'h1);
      checkOutput("bs_addr",  32'(mem_addr), 32'h0);
      tick();
      checkOutput("bs_hold_req", 32'(mem_req), 32'h1);
      checkOutput("bs_hold_be",  32'(mem_be),  32'h8);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      checkOutput("bs_done", 32'(done), 32'h1);
      checkOutput("bs_data_kept", data_out, 32'hDEAD_BEEF);
      tick();

      $display("[TB] half load");
      issue(1'b1, 1'b0, 2'b01, 32'h0000_2006, 32'h0);
      checkOutput("hl_be",   32'(mem_be),   32'hC);
      checkOutput("hl_addr", 32'(mem_addr), 32'h1);
      mem_ack   = 1'b1;
      mem_rdata = 32'h8001_1234;
      tick();
      mem_ack = 1'b0;
      checkOutput("hl_data", data_out, 32'h0000_8001);
      tick();

      $display("[TB] byte load lane 1");
      issue(1'b1, 1'b0, 2'b00, 32'h0000_2FF1, 32'h0);
      checkOutput("bl_be",   32'(mem_be),   32'h2);
      checkOutput("bl_addr", 32'(mem_addr), 32'h3FC);
      mem_ack   = 1'b1;
      mem_rdata = 32'h1122_3344;
      tick();
      mem_ack = 1'b0;
      checkOutput("bl_data", data_out, 32'h0000_0033);
      tick();

      $display("[TB] misaligned half");
      issue(1'b1, 1'b0, 2'b01, 32'h0000_2005, 32'h0);
      checkOutput("mis_req",   32'(mem_req), 32'h0);
      checkOutput("mis_done",  32'(done),    32'h1);
      checkOutput("mis_fault", 32'(fault),   32'h1);
      tick();
      checkOutput("mis_fault_hold", 32'(fault), 32'h1);
      checkOutput("mis_ready",      32'(ready), 32'h1);

      $display("[TB] range and illegal requests");
      issue(1'b1, 1'b0, 2'b10, 32'h0000_1FFC, 32'h0);
      checkOutput("low_fault", 32'(fault),   32'h2);
      checkOutput("low_req",   32'(mem_req), 32'h0);
      checkOutput("low_done",  32'(done),    32'h1);
      tick();
      issue(1'b1, 1'b0, 2'b10, 32'h0000_3000, 32'h0);
      checkOutput("high_fault", 32'(fault),   32'h2);
      checkOutput("high_req",   32'(mem_req), 32'h0);
      tick();
      issue(1'b1, 1'b0, 2'b11, 32'h0000_2000, 32'h0);
      checkOutput("size11_fault", 32'(fault), 32'h2);
      tick();
      issue(1'b1, 1'b1, 2'b10, 32'h0000_2000, 32'h0);
      checkOutput("rdwd_fault", 32'(fault),   32'h2);
      checkOutput("rdwd_req",   32'(mem_req), 32'h0);
      tick();
      issue(1'b1, 1'b0, 2'b10, 32'h0000_2FFC, 32'h0);
      checkOutput("top_word_fault_clr", 32'(fault),    32'h0);
      checkOutput("top_word_addr",      32'(mem_addr), 32'h3FF);
      mem_ack   = 1'b1;
      mem_rdata = 32'h0102_0304;
      tick();
      mem_ack = 1'b0;
      checkOutput("top_word_data", data_out, 32'h0102_0304);
      tick();

      $display("[TB] timeout");
      issue(1'b1, 1'b0, 2'b10, 32'h0000_2008, 32'h0);
      req_cycles = 0;
      while (mem_req && req_cycles < 40) begin
         req_cycles++;
         tick();
      end
      checkOutput("to_req_cycles", 32'(req_cycles), 32'd15);
      checkOutput("to_done",  32'(done),  32'h1);
      checkOutput("to_fault", 32'(fault), 32'h3);
      checkOutput("to_data",  data_out,   32'h0102_0304);
      mem_ack   = 1'b1;
      mem_rdata = 32'hFFFF_FFFF;
      tick();
      mem_ack = 1'b0;
      checkOutput("late_ack_data",  data_out,      32'h0102_0304);
      checkOutput("late_ack_fault", 32'(fault),    32'h3);
      checkOutput("late_ack_req",   32'(mem_req),  32'h0);
      checkOutput("late_ack_ready", 32'(ready),    32'h1);
      checkOutput("late_ack_done",  32'(done),     32'h0);

      $display("[TB] reset during access");
      issue(1'b1, 1'b0, 2'b10, 32'h0000_2010, 32'h0);
      tick();
      tick();
      rst = 1'b0;
      tick();
      checkOutput("mid_rst_req",   32'(mem_req), 32'h0);
      checkOutput("mid_rst_busy",  32'(busy),    32'h0);
      checkOutput("mid_rst_done",  32'(done),    32'h0);
      checkOutput("mid_rst_fault", 32'(fault),   32'h0);
      checkOutput("mid_rst_ready", 32'(ready),   32'h0);
      rst = 1'b1;
      tick();
      checkOutput("post_rst_ready", 32'(ready), 32'h1);
      issue(1'b1, 1'b0, 2'b10, 32'h0000_200C, 32'h0);
      checkOutput("post_rst_addr", 32'(mem_addr), 32'h3);
      mem_ack   = 1'b1;
      mem_rdata = 32'h0BAD_F00D;
      tick();
      mem_ack = 1'b0;
      checkOutput("post_rst_done",  32'(done),  32'h1);
      checkOutput("post_rst_data",  data_out,   32'h0BAD_F00D);
      checkOutput("post_rst_fault", 32'(fault), 32'h0);
      tick();

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
